// File: rtl/hs_access_engine_if.sv
// rtl/hs_access_engine_if.sv - high-score RAM port between the access engine and the CPU board
`timescale 1ns/1ps

interface hs_access_engine_if;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_write;

  modport master (
    output hs_address,
    output hs_data_in,
    output hs_write,
    input  hs_data_out
  );

  modport slave (
    input  hs_address,
    input  hs_data_in,
    input  hs_write,
    output hs_data_out
  );
endinterface

// File: rtl/hs_access_engine.sv
// rtl/hs_access_engine.sv - restores a downloaded high-score table into core RAM, then mirrors it once per frame
`timescale 1ns/1ps

module hs_access_engine #(
  parameter logic [15:0] HS_START    = 16'h0000,
  parameter int          HS_LEN      = 64,
  parameter logic [7:0]  HS_INDEX    = 8'd4,
  parameter int          RD_LAT      = 1,
  parameter int          HOLD_FRAMES = 180
) (
  input  logic               clk_49m,
  input  logic               reset,
  input  logic               vblank,
  input  logic [7:0]         ioctl_index,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_data,
  input  logic               ioctl_wr,
  input  logic               ioctl_download,
  input  logic               ioctl_upload,
  output logic [7:0]         ioctl_din,
  hs_access_engine_if.master hs,
  output logic               pause_req,
  output logic               restored
);

  localparam int          AW         = (HS_LEN > 1) ? $clog2(HS_LEN) : 1;
  localparam logic [24:0] LEN_A      = 25'(HS_LEN);
  localparam logic [8:0]  LEN_I      = 9'(HS_LEN);
  localparam logic [8:0]  LAST_I     = 9'(HS_LEN - 1);
  localparam logic [15:0] LAST_FRAME = 16'(HOLD_FRAMES - 1);
  localparam logic [2:0]  LAST_W     = 3'(RD_LAT + 1);

  typedef enum logic [1:0] {WAIT, RESTORE, RUN, MIRROR} state_t;

  state_t      state;
  logic [7:0]  hs_buf [HS_LEN];
  logic [8:0]  idx;
  logic [2:0]  wcnt;
  logic [15:0] frame_cnt;
  logic        loaded;
  logic        vblank_q;

  logic vb_rise;
  logic dl_active;
  logic dl_hit;
  logic mirror_cap;

  assign vb_rise    = vblank && !vblank_q;
  assign dl_active  = ioctl_download && (ioctl_index == HS_INDEX);
  assign dl_hit     = dl_active && ioctl_wr && (ioctl_addr < LEN_A);
  assign mirror_cap = (state == MIRROR) && (wcnt == LAST_W) && !dl_active;

  // Buffer contents survive reset so a table is never lost to a core reset.
  always_ff @(posedge clk_49m) begin
    if (dl_hit)
      hs_buf[ioctl_addr[AW-1:0]] <= ioctl_data;
    else if (mirror_cap)
      hs_buf[idx[AW-1:0]] <= hs.hs_data_out;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state         <= WAIT;
      frame_cnt     <= '0;
      loaded        <= 1'b0;
      idx           <= '0;
      wcnt          <= '0;
      vblank_q      <= 1'b0;
      ioctl_din     <= 8'h00;
      hs.hs_address <= HS_START;
      hs.hs_data_in <= 8'h00;
      hs.hs_write   <= 1'b0;
      pause_req     <= 1'b0;
      restored      <= 1'b0;
    end else begin
      vblank_q <= vblank;

      if (ioctl_upload && (ioctl_index == HS_INDEX))
        ioctl_din <= (ioctl_addr < LEN_A) ? hs_buf[ioctl_addr[AW-1:0]] : 8'h00;

      if (dl_active) begin
        state       <= WAIT;
        frame_cnt   <= '0;
        restored    <= 1'b0;
        hs.hs_write <= 1'b0;
        pause_req   <= 1'b0;
        idx         <= '0;
        wcnt        <= '0;
        if (ioctl_wr)
          loaded <= 1'b1;
      end else begin
        case (state)
          WAIT: begin
            if (vb_rise) begin
              if (frame_cnt == LAST_FRAME) begin
                frame_cnt <= '0;
                idx       <= '0;
                if (loaded) begin
                  state     <= RESTORE;
                  pause_req <= 1'b1;
                end else begin
                  state <= RUN;
                end
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end
          end

          // Address, data and strobe are all registered on the same edge, so they stay aligned.
          RESTORE: begin
            if (idx == LEN_I) begin
              hs.hs_write <= 1'b0;
              pause_req   <= 1'b0;
              restored    <= 1'b1;
              loaded      <= 1'b0;
              state       <= RUN;
            end else begin
              hs.hs_address <= HS_START + 16'(idx);
              hs.hs_data_in <= hs_buf[idx[AW-1:0]];
              hs.hs_write   <= 1'b1;
              idx           <= idx + 9'd1;
            end
          end

          RUN: begin
            if (vb_rise && !ioctl_upload) begin
              state         <= MIRROR;
              idx           <= '0;
              wcnt          <= '0;
              hs.hs_address <= HS_START;
            end
          end

          // Each byte holds its address for RD_LAT+2 clocks; the capture lands on the last one.
          MIRROR: begin
            if (wcnt == LAST_W) begin
              wcnt <= '0;
              if (idx == LAST_I) begin
                state <= RUN;
              end else begin
                idx           <= idx + 9'd1;
                hs.hs_address <= HS_START + 16'(idx) + 16'd1;
              end
            end else begin
              wcnt <= wcnt + 3'd1;
            end
          end

          default: state <= WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_access_engine.sv
// tb/tb_hs_access_engine.sv - self-checking bench for hs_access_engine
`timescale 1ns/1ps

module tb_hs_access_engine;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b1;
  logic        vblank = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_din;
  logic        pause_req;
  logic        restored;

  hs_access_engine_if hs_bus();

  hs_access_engine dut (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .vblank         (vblank),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_download (ioctl_download),
    .ioctl_upload   (ioctl_upload),
    .ioctl_din      (ioctl_din),
    .hs             (hs_bus),
    .pause_req      (pause_req),
    .restored       (restored)
  );

  always #10 clk_49m = ~clk_49m;

  // Core RAM with one clock of read latency.
  logic [7:0] core_ram [65536];
  always @(posedge clk_49m) begin
    if (hs_bus.hs_write) core_ram[hs_bus.hs_address] <= hs_bus.hs_data_in;
    hs_bus.hs_data_out <= core_ram[hs_bus.hs_address];
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] mdl_buf [64];
  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks = 0;
  int         failures = 0;
  int         wr_count = 0;
  bit         flush_req = 0;
  bit         din_pend = 0;
  logic [7:0] din_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the scoreboard and the buffer model.
  always @(negedge clk_49m) begin
    if (!reset) begin
      if (hs_bus.hs_write) begin
        wr_count++;
        chk("pause_during_write", pause_req, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h expected=none", hs_bus.hs_address, hs_bus.hs_data_in);
        end else begin
          mon_e = exp_q.pop_front();
          chk("restore_addr", hs_bus.hs_address, mon_e.a);
          chk("restore_data", hs_bus.hs_data_in, mon_e.d);
        end
      end
      if (flush_req) begin
        exp_q.delete();
        flush_req = 0;
      end
      if (din_pend) chk("upload_din", ioctl_din, din_exp);
      din_pend = ioctl_upload && (ioctl_index == 8'd4);
      if (din_pend) din_exp = (ioctl_addr < 25'd64) ? mdl_buf[ioctl_addr[5:0]] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic edge_up();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_download = 1'b1;
    ioctl_index    = 8'd4;
    ioctl_addr     = a;
    ioctl_data     = d;
    ioctl_wr       = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    if (a < 25'd64) mdl_buf[a[5:0]] = d;
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic push_restore();
    for (int k = 0; k < 64; k++) exp_q.push_back('{a: 16'(k), d: mdl_buf[6'(k)]});
  endtask

  task automatic wait_restore(input string name);
    int n;
    n = 0;
    while (!restored && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_restored"}, restored, 1);
    chk({name, "_pause_dropped"}, pause_req, 0);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int w0;
    int errs;
    int n;
    for (int a = 0; a < 65536; a++) core_ram[a] = 8'(a) ^ 8'h5A;
    for (int k = 0; k < 64; k++) mdl_buf[k] = 8'h00;

    tick();
    tick();
    chk("rst_ioctl_din", ioctl_din, 8'h00);
    chk("rst_hs_address", hs_bus.hs_address, 16'h0000);
    chk("rst_hs_data_in", hs_bus.hs_data_in, 8'h00);
    chk("rst_hs_write", hs_bus.hs_write, 0);
    chk("rst_pause_req", pause_req, 0);
    chk("rst_restored", restored, 0);
    reset = 1'b0;
    tick();

    // No download: hold period ends in RUN without any write.
    w0 = wr_count;
    frames(179);
    edge_up();
    chk("t1_no_pause", pause_req, 0);
    tick();
    tick();
    chk("t1_no_writes", wr_count - w0, 0);
    chk("t1_not_restored", restored, 0);

    // Next rising edge starts a mirror: 64 addresses, 3 clocks each.
    edge_up();
    errs = 0;
    for (int k = 0; k < 192; k++) begin
      if (hs_bus.hs_address !== 16'(k / 3)) errs++;
      tick();
    end
    chk("t1_mirror_addr_trace_errors", errs, 0);
    repeat (10) tick();
    chk("t1_mirror_end_addr", hs_bus.hs_address, 16'h003F);
    for (int k = 0; k < 64; k++) mdl_buf[k] = core_ram[k];

    // Upload the mirrored table, including addresses past the end.
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    for (int a = 0; a <= 70; a++) begin
      ioctl_addr = 25'(a);
      tick();
      if (a == 5)  chk("t2_upload_lit_5", ioctl_din, 8'h5F);
      if (a == 63) chk("t2_upload_lit_63", ioctl_din, 8'h65);
      if (a == 64) chk("t2_upload_lit_64", ioctl_din, 8'h00);
      if (a == 70) chk("t2_upload_lit_70", ioctl_din, 8'h00);
    end

    // Upload held across a rising edge blocks the mirror.
    ioctl_addr = 25'd3;
    edge_up();
    tick();
    tick();
    chk("t5_no_mirror_during_upload", hs_bus.hs_address, 16'h003F);
    ioctl_upload = 1'b0;
    tick();
    edge_up();
    chk("t5_mirror_after_upload_drop", hs_bus.hs_address, 16'h0000);
    repeat (200) tick();
    chk("t5_mirror_done", hs_bus.hs_address, 16'h003F);

    // Download 0x00..0x3F and restore it.
    for (int k = 0; k < 64; k++) dl_byte(25'(k), 8'(k));
    dl_end();
    w0 = wr_count;
    frames(179);
    chk("t3_hold_no_write", wr_count - w0, 0);
    push_restore();
    edge_up();
    chk("t3_pause_on_edge", pause_req, 1);
    wait_restore("t3");
    chk("t3_write_count", wr_count - w0, 64);
    chk("t3_core_ram_2a", core_ram[16'h002A], 8'h2A);
    chk("t3_core_ram_3f", core_ram[16'h003F], 8'h3F);

    // Download during a restore aborts it; the later restore carries the new data.
    for (int k = 0; k < 64; k++) dl_byte(25'(k), 8'(k) ^ 8'hC3);
    dl_end();
    frames(179);
    push_restore();
    w0 = wr_count;
    edge_up();
    n = 0;
    while ((wr_count - w0) < 20 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_reached_byte20", ((wr_count - w0) >= 20) ? 1 : 0, 1);
    flush_req = 1;
    dl_byte(25'd0, 8'h01);
    chk("t4_write_dropped", hs_bus.hs_write, 0);
    chk("t4_restored_clear", restored, 0);
    for (int k = 1; k < 64; k++) dl_byte(25'(k), 8'((k * 7 + 1) & 255));
    dl_end();
    w0 = wr_count;
    frames(179);
    chk("t4_hold_no_write", wr_count - w0, 0);
    push_restore();
    edge_up();
    chk("t4_pause_on_edge", pause_req, 1);
    wait_restore("t4");
    chk("t4_write_count", wr_count - w0, 64);
    chk("t4_core_ram_10", core_ram[16'h000A], 8'h47);

    // Out-of-range download bytes leave the buffer alone but still arm a restore.
    for (int a = 64; a <= 100; a++) dl_byte(25'(a), 8'hEE);
    dl_end();
    w0 = wr_count;
    frames(179);
    push_restore();
    edge_up();
    chk("t6_pause_on_edge", pause_req, 1);
    wait_restore("t6");
    chk("t6_write_count", wr_count - w0, 64);
    chk("t6_core_ram_10", core_ram[16'h000A], 8'h47);
    chk("t6_core_ram_40_untouched", core_ram[16'h0040], 8'h1A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_access_engine.md
Name: hs_access_engine

Overview:
- Initiator side of the core's high-score RAM port (hs_address / hs_data_in / hs_data_out / hs_write); the CPU board is the responder.
- Restores a high-score table downloaded from the HPS into core RAM once the game has initialised.
- Afterwards, mirrors that core RAM region into a local buffer once per frame, so the HPS can upload it over ioctl at any time.
- Sits beside the game top level in the MiSTer wrapper and shares the ioctl bus with the ROM loader.

Parameters:
- HS_START, 16'h0000: first core RAM address of the score table.
- HS_LEN, 64: table length in bytes; range 1..256.
- HS_INDEX, 8'd4: ioctl_index value used for high-score download and upload.
- RD_LAT, 1: clocks from a hs_address change to valid hs_data_out; range 0..3.
- HOLD_FRAMES, 180: vblank rising edges to wait after reset/download before restoring.

Ports:
- clk_49m  in  1  system clock, 49.152MHz
- reset  in  1  asynchronous, active-high
- vblank  in  1  core video_vblank; level, synchronous to clk_49m
- ioctl_index  in  8  HPS transfer index
- ioctl_addr  in  25  HPS byte address
- ioctl_data  in  8  HPS download data
- ioctl_wr  in  1  download write strobe, one clock per byte
- ioctl_download  in  1  download active
- ioctl_upload  in  1  upload active
- ioctl_din  out  8  upload data to HPS
- hs_address  out  16  core RAM address
- hs_data_in  out  8  write data to core RAM
- hs_data_out  in  8  read data from core RAM
- hs_write  out  1  core RAM write strobe, one clock per byte
- pause_req  out  1  request core CPU pause while restoring
- restored  out  1  sticky; set when a restore completes

Behaviour:
- Reset (async, active-high):
  - Outputs: ioctl_din=0, hs_address=HS_START, hs_data_in=0, hs_write=0, pause_req=0, restored=0.
  - Internal: state=WAIT, frame counter=0, loaded=0.
  - Buffer contents are not reset.
- Buffer: HS_LEN x 8 single-clock RAM; index width is 8 bits.
- Download capture:
  - Condition: ioctl_download && ioctl_index==HS_INDEX && ioctl_wr && ioctl_addr<HS_LEN.
  - Action: buf[ioctl_addr] <= ioctl_data and loaded <= 1.
  - Bytes at addresses >= HS_LEN are ignored.
- Any matching download activity forces state=WAIT, frame counter=0, restored=0 and aborts any restore or mirror in progress. hs_write drops to 0 on the next clock.
- Vblank edge: vb_rise = vblank && !vblank_q, with vblank_q registered.
- State machine:
  - WAIT: frame counter increments on each vb_rise. At count==HOLD_FRAMES:
    - loaded=1 -> RESTORE, i=0, pause_req=1.
    - loaded=0 -> RUN.
  - RESTORE: one byte per clock. hs_address=HS_START+i, hs_data_in=buf[i], hs_write=1.
    - The buffer read is pipelined so address, data and strobe stay aligned.
    - After byte HS_LEN-1: hs_write=0, pause_req=0, restored=1, loaded=0, go to RUN.
    - Exactly HS_LEN write strobes, consecutive addresses; 16-bit address wrap allowed.
  - RUN: on vb_rise with ioctl_upload=0 -> MIRROR, i=0.
  - MIRROR: per byte:
    - Drive hs_address=HS_START+i.
    - Wait RD_LAT+1 clocks.
    - buf[i] <= hs_data_out.
    - i++ (HS_LEN*(RD_LAT+2) clocks total, then RUN).
    - hs_write stays 0 throughout.
- Upload:
  - While ioctl_upload=1 and ioctl_index==HS_INDEX: ioctl_din <= buf[ioctl_addr[7:0]], registered, one clock latency.
  - Addresses >= HS_LEN return 8'h00.
  - A MIRROR pass already in progress completes; no new pass starts while ioctl_upload=1.
  - Buffer writes from mirror and the upload read never conflict: the buffer is dual-port, with read on the ioctl side.
- vblank held high does not retrigger anything; only rising edges count.
- Reset mid-RESTORE: hs_write and pause_req drop immediately (asynchronous). loaded=0, so no restore happens after reset unless the HPS downloads again.

Test Plan:
- Download 64 bytes (0x00..0x3F) at index 4, then 180 vblank edges -> within 1 clk of the 180th edge pause_req=1. 64 consecutive hs_write pulses at 0x0000..0x003F carrying data 0x00..0x3F. Then pause_req=0 and restored=1.
- Reset with no download, 180 frames -> no hs_write ever asserted. Next vb_rise starts a mirror: 64 addresses, each held 3 clocks (RD_LAT=1).
- Mirror with core model RAM[a]=a^0x5A, then upload at index 4 reading addresses 0..70 -> ioctl_din = addr^0x5A one clock after each addr. Addresses 64..70 return 0x00.
- Download starting mid-RESTORE (byte 20) -> hs_write low next clock, restored=0, state WAIT. After a further 180 frames, the full 64-byte restore uses the new data.
- ioctl_upload held across a vb_rise in RUN -> no mirror starts. Deasserting upload -> mirror starts on the next vb_rise.
- Download bytes to addresses 64..100 only -> buffer unchanged, but loaded=1. Restore still writes 64 bytes.
